// File: rtl/chime_sequencer.sv
// chime_sequencer: latches button presses and plays each selected sound word for a fixed hold time, followed by a silent gap.
module chime_sequencer #(
    parameter int WIDTH       = 24,
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] sounds,
    input  logic [CHANNELS-1:0]       press,
    output logic [WIDTH-1:0]          out,
    output logic [CW-1:0]             active_ch,
    output logic                      busy,
    output logic [CHANNELS-1:0]       pending,
    output logic                      done
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int NW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]          state;
    logic [NW-1:0]       cnt;
    logic [CW-1:0]       winner;
    logic [CHANNELS-1:0] start_clr;
    logic [WIDTH-1:0]    words [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_word
        assign words[i] = sounds[i*WIDTH +: WIDTH];
    end

    always_comb begin
        winner = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (pending[i]) winner = CW'(i);
    end

    // Isolate the lowest set pending bit; it is cleared only when a sound actually starts.
    assign start_clr = (state == IDLE) ? (pending & (~pending + 1'b1)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= '0;
            active_ch <= '0;
            busy      <= 1'b0;
            pending   <= '0;
            done      <= 1'b0;
        end else begin
            pending <= (pending & ~start_clr) | press;
            done    <= 1'b0;
            if (state == IDLE) begin
                if (|pending) begin
                    state     <= PLAY;
                    active_ch <= winner;
                    out       <= words[winner];
                    busy      <= 1'b1;
                    cnt       <= NW'(HOLD_CYCLES - 1);
                end
            end else if (state == PLAY) begin
                if (cnt == '0) begin
                    state <= GAP;
                    out   <= '0;
                    done  <= 1'b1;
                    cnt   <= NW'(GAP_CYCLES - 1);
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    active_ch <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/chime_sequencer.md
Name: chime_sequencer

Overview:
- Parametrised successor to the two-input doorbell chime mux. Selects among CHANNELS sound words of WIDTH bits each.
- Each button press is latched. Pending presses are arbitrated by fixed priority, and each selected sound is played for a programmable number of cycles, followed by a silent gap.
- Sits between the doorbell button inputs and the sound output driver. Replaces the combinational select with a clocked player that queues presses.

Parameters:
- WIDTH, 24, bit width of each sound word and of out.
- CHANNELS, 4, number of sound sources/buttons (2..16).
- HOLD_CYCLES, 8, clock cycles each sound is held on out (>=1).
- GAP_CYCLES, 2, silent cycles after each sound before the next may start (>=1).
- CW, $clog2(CHANNELS), width of channel index (derived, localparam).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- sounds  input  CHANNELS*WIDTH  packed sound words; channel i = sounds[i*WIDTH +: WIDTH].
- press  input  CHANNELS  per-channel press request, level sampled each clk.
- out  output  WIDTH  current sound word; 0 when silent.
- active_ch  output  CW  index of channel being played; 0 when idle.
- busy  output  1  high in PLAY or GAP.
- pending  output  CHANNELS  latched, not-yet-started requests.
- done  output  1  one-cycle pulse when a sound finishes its hold time.

Behaviour:
- Reset: with rst high at an edge, the following are cleared to 0: out, active_ch, busy, pending, done, and the counter; state=IDLE. rst overrides everything, including mid-PLAY or mid-GAP; presses in that cycle are dropped.
- Pending latch: at each edge, pending[i] <= (pending[i] & ~start_clr[i]) | press[i].
  - Set wins over clear in the same cycle, so a re-press of the channel being started is queued again.
  - Holding press high re-queues that channel continuously.
- Arbitration: lowest-index set bit of pending wins. The decision is made only in IDLE, never preempts a sound in progress, and is evaluated from registered pending only (not from raw press).
- FSM states: IDLE, PLAY, GAP.
  - IDLE -> PLAY when |pending.
    - At that edge: active_ch <= winner; out <= snapshot of sounds[winner]; busy <= 1; counter <= HOLD_CYCLES-1; start_clr[winner]=1.
  - PLAY: out holds the snapshot. Later changes on sounds do not affect it. Counter decrements each cycle.
    - At the edge where counter==0: -> GAP; out <= 0; done <= 1 for exactly one cycle; counter <= GAP_CYCLES-1.
  - GAP: out=0, busy=1, active_ch keeps its last value. Counter decrements.
    - At the edge where counter==0: -> IDLE; busy <= 0; active_ch <= 0.
- Latency: a press sampled at edge k sets pending at k. If the FSM is in IDLE, PLAY is entered at edge k+1 and out is valid from k+1 for exactly HOLD_CYCLES cycles.
  - Back-to-back sounds are separated by exactly GAP_CYCLES+1 cycles of out=0 (GAP plus one IDLE cycle).
- done is 0 in all cycles except the first GAP cycle.
- Presses arriving in PLAY or GAP are queued and served in priority order after IDLE. Multiple presses of the same channel collapse into one pending bit.
- A sound word of value 0 is played normally: busy=1, done still pulses.
- CHANNELS=1: CW is forced to 1, and active_ch stays 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, press=0 -> out=0, busy=0, pending=0, done never pulses over 20 cycles.
- Single press, defaults: sounds ch2=24'hABCDEF, press=4'b0100 for 1 cycle at edge k -> pending[2]=1 at k; out=24'hABCDEF and active_ch=2 from k+1 to k+8; done=1 at k+9 only; out=0 and busy=1 at k+9 and k+10; busy=0 at k+11.
- Simultaneous presses: press=4'b1010 for one cycle -> ch1 plays first (8 cycles); 2 gap cycles plus 1 idle cycle with out=0; then ch3 plays; two done pulses total; pending=0 at end.
- Snapshot and queueing: during ch0 playback, change sounds ch0 from 24'h000111 to 24'h222222 and press ch0 again -> out stays 24'h000111 for the whole hold; second playback outputs 24'h222222.
- Reset mid-operation: assert rst at the 4th PLAY cycle with pending=4'b1000 -> next cycle out=0, busy=0, pending=0; no done pulse; nothing plays afterwards without new presses.
- Parameter sweep: CHANNELS=8, WIDTH=16, HOLD_CYCLES=1, GAP_CYCLES=1, press ch7 -> out valid for exactly 1 cycle, active_ch=3'd7, done the next cycle, busy for 2 cycles total.
